stack_mem_controller: RTL and testbench
=======================================

Name: stack_mem_controller

Overview:
- Initiator side of the data-memory port. Sits in the MEM pipeline stage between the execute/memory pipeline register and data memory.
- Accepts load, store, stack, call/return and interrupt-entry/exit requests from the pipeline.
- Owns the stack pointer (SP) and sequences multi-cycle operations.
- Drives the memory's asynchronous-read and synchronous-write ports.

Parameters:
SP_RESET, 8'hFF, SP value after reset; the stack grows downward
FLAG_W, 4, width of the CCR flag bundle saved and restored by INT/RTI

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
req_valid  input  1  pipeline presents a request
req_ready  output  1  controller can accept a request this cycle
req_op  input  3  0 LOAD, 1 STORE, 2 PUSH, 3 POP, 4 CALL, 5 RET, 6 INT, 7 RTI
req_addr  input  8  effective address for LOAD/STORE
req_data  input  8  store/push data
req_pc  input  8  return PC for CALL/INT
req_flags  input  FLAG_W  flags to save on INT
resp_valid  output  1  one-cycle pulse: the result fields are valid
resp_data  output  8  LOAD/POP data
resp_pc  output  8  popped PC for RET/RTI
resp_flags  output  FLAG_W  popped flags for RTI
resp_pc_valid  output  1  with resp_valid: resp_pc must be loaded into the PC
sp  output  8  current stack pointer
stall  output  1  high while a multi-cycle operation is in flight
mem_read_addr  output  8  memory read address
mem_read_data  input  8  asynchronous read data for mem_read_addr
mem_write_enable  output  1  memory write strobe
mem_write_addr  output  8  memory write address
mem_write_data  output  8  memory write data

Behaviour:
- Reset: synchronous, active-high; overrides everything and aborts any in-flight operation.
  - Reset values: sp=SP_RESET, state=IDLE, resp_valid=0, resp_pc_valid=0, resp_data=0, resp_pc=0, resp_flags=0, stall=0.
  - While rst is high: mem_write_enable=0 and req_ready=0.
- Handshake:
  - Accept when req_valid & req_ready.
  - req_ready = (state==IDLE) & ~rst.
  - Request inputs are sampled only on the accept cycle.
- Memory drive:
  - Memory outputs are combinational from the current state and the accepted request.
  - Read data is captured on the same rising edge that completes the op.
- States: IDLE, INT2, RTI2.
- IDLE single-cycle ops (the result registers update at the accept edge; resp_valid is high the next cycle):
  - LOAD: read addr=req_addr; resp_data<=mem_read_data.
  - STORE: write mem[req_addr]<=req_data; no resp_valid.
  - PUSH: write mem[sp]<=req_data; sp<=sp-1.
  - POP: read addr=sp+1; resp_data<=mem_read_data; sp<=sp+1.
  - CALL: write mem[sp]<=req_pc; sp<=sp-1; no resp_valid.
  - RET: read addr=sp+1; resp_pc<=data; sp<=sp+1; resp_pc_valid=1.
- INT (two cycles):
  - Accept cycle: write mem[sp]<=req_pc; latch req_flags; sp<=sp-1; go to INT2; stall=1.
  - INT2: write mem[sp]<=latched flags, zero-extended to 8 bits; sp<=sp-1; go to IDLE; no resp_valid.
- RTI (two cycles):
  - Accept cycle: read sp+1; resp_flags<=data[FLAG_W-1:0]; sp<=sp+1; go to RTI2; stall=1.
  - RTI2: read sp+1; resp_pc<=data; sp<=sp+1; go to IDLE. resp_valid and resp_pc_valid are high the following cycle.
- Stall: stall=1 in the INT/RTI accept cycle and in INT2/RTI2, so the pipeline holds.
- SP arithmetic: 8-bit modulo; 8'h00-1 wraps to 8'hFF and 8'hFF+1 wraps to 8'h00. With the guard feature out, wrap is silent.
- Writes occur only on accepted ops or in INT2. At most one read and one write per cycle.
- Outputs: resp_valid is a single-cycle pulse. resp_data/resp_pc/resp_flags hold their value until the next update.
- Write-then-read: a write in cycle N followed by a read of the same address in cycle N+1 must return the new value. No forwarding is needed because memory writes on the edge.

Optional Feature:
- Macro: STACK_GUARD_EN.
- When defined:
  - Adds output stack_fault (1 bit, sticky, reset 0).
  - Adds parameters SP_LIMIT (default 8'h80) and SP_RESET as the top of stack.
  - A PUSH/CALL/INT step with sp==SP_LIMIT sets stack_fault, suppresses the write and the SP update, and the FSM returns to IDLE.
  - A POP/RET/RTI step with sp==SP_RESET sets stack_fault, suppresses the SP update and forces the popped result to 0.
  - stack_fault is cleared only by rst.
- When undefined: no stack_fault port, SP wraps silently.

Test Plan:
- Reset -> sp=8'hFF, resp_valid=0, stall=0, mem_write_enable=0.
- STORE addr 8'h10 data 8'h5A, then LOAD 8'h10 -> resp_valid the cycle after the LOAD accept, resp_data=8'h5A.
- PUSH 8'hA1, PUSH 8'hB2, POP, POP -> sp steps FF,FE,FD,FE,FF; mem[FF]=A1, mem[FE]=B2; POP results B2 then A1.
- CALL pc 8'h33, then RET -> mem[FF]=33; resp_pc=8'h33 with resp_pc_valid; sp back to FF.
- INT pc 8'h40 flags 4'b1010, then RTI:
  - INT: stall for 1 extra cycle; mem[FF]=40, mem[FE]=0A.
  - RTI: resp_flags=4'b1010, resp_pc=8'h40; sp back to FF.
  - req_ready=0 during INT2/RTI2.
- rst asserted in INT2 -> no second write (mem[FE] unchanged), sp=FF, state IDLE.
- STACK_GUARD_EN only: POP at sp=FF -> stack_fault=1, sp stays FF.

Source files
------------

// File: rtl/stack_mem_controller.sv
// Data-memory initiator for the MEM stage: owns the stack pointer and sequences
// load/store/stack/call/return/interrupt traffic. Optional stack guard: STACK_GUARD_EN.
module stack_mem_controller #(
    parameter logic [7:0]  SP_RESET = 8'hFF,
`ifdef STACK_GUARD_EN
    parameter logic [7:0]  SP_LIMIT = 8'h80,
`endif
    parameter int unsigned FLAG_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [7:0]        req_addr,
    input  logic [7:0]        req_data,
    input  logic [7:0]        req_pc,
    input  logic [FLAG_W-1:0] req_flags,
    output logic              resp_valid,
    output logic [7:0]        resp_data,
    output logic [7:0]        resp_pc,
    output logic [FLAG_W-1:0] resp_flags,
    output logic              resp_pc_valid,
    output logic [7:0]        sp,
`ifdef STACK_GUARD_EN
    output logic              stack_fault,
`endif
    output logic              stall,
    output logic [7:0]        mem_read_addr,
    input  logic [7:0]        mem_read_data,
    output logic              mem_write_enable,
    output logic [7:0]        mem_write_addr,
    output logic [7:0]        mem_write_data
);

    localparam int unsigned DW = 8;

    typedef enum logic [2:0] {
        OP_LOAD  = 3'd0,
        OP_STORE = 3'd1,
        OP_PUSH  = 3'd2,
        OP_POP   = 3'd3,
        OP_CALL  = 3'd4,
        OP_RET   = 3'd5,
        OP_INT   = 3'd6,
        OP_RTI   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INT2 = 2'd1,
        S_RTI2 = 2'd2
    } state_e;

    state_e            state_q;
    logic [DW-1:0]     sp_q;
    logic [FLAG_W-1:0] flags_q;
    logic              resp_valid_q;
    logic              resp_pc_valid_q;
    logic [DW-1:0]     resp_data_q;
    logic [DW-1:0]     resp_pc_q;
    logic [FLAG_W-1:0] resp_flags_q;

    op_e           op;
    logic          accept;
    logic          idle;
    logic [DW-1:0] sp_inc;
    logic [DW-1:0] sp_dec;
    logic          push_fault;
    logic          pop_fault;

    assign op     = op_e'(req_op);
    assign idle   = (state_q == S_IDLE);
    assign accept = req_valid & req_ready;
    assign sp_inc = sp_q + DW'(1);
    assign sp_dec = sp_q - DW'(1);

`ifdef STACK_GUARD_EN
    logic stack_fault_q;
    logic fault_evt;

    // Overflow/underflow detection at the configured stack bounds
    assign push_fault = (sp_q == SP_LIMIT);
    assign pop_fault  = (sp_q == SP_RESET);

    always_comb begin
        fault_evt = 1'b0;
        if (!rst) begin
            if (accept) begin
                case (op)
                    OP_PUSH, OP_CALL, OP_INT: fault_evt = push_fault;
                    OP_POP,  OP_RET,  OP_RTI: fault_evt = pop_fault;
                    default:                  fault_evt = 1'b0;
                endcase
            end else if (state_q == S_INT2) begin
                fault_evt = push_fault;
            end else if (state_q == S_RTI2) begin
                fault_evt = pop_fault;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stack_fault_q <= 1'b0;
        end else if (fault_evt) begin
            stack_fault_q <= 1'b1;
        end
    end

    assign stack_fault = stack_fault_q;
`else
    assign push_fault = 1'b0;
    assign pop_fault  = 1'b0;
`endif

    assign req_ready = idle & ~rst;

    // Pipeline hold: INT/RTI accept cycle plus their second step
    always_comb begin
        stall = 1'b0;
        if (!rst) begin
            if (idle) begin
                stall = req_valid & ((op == OP_INT) | (op == OP_RTI));
            end else begin
                stall = 1'b1;
            end
        end
    end

    // Memory port drive, combinational from state and the request being accepted
    always_comb begin
        mem_read_addr    = sp_inc;
        mem_write_enable = 1'b0;
        mem_write_addr   = sp_q;
        mem_write_data   = req_data;
        if (!rst) begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        case (op)
                            OP_LOAD: mem_read_addr = req_addr;
                            OP_STORE: begin
                                mem_write_enable = 1'b1;
                                mem_write_addr   = req_addr;
                            end
                            OP_PUSH: mem_write_enable = ~push_fault;
                            OP_CALL, OP_INT: begin
                                mem_write_enable = ~push_fault;
                                mem_write_data   = req_pc;
                            end
                            default: mem_read_addr = sp_inc;
                        endcase
                    end
                end
                S_INT2: begin
                    mem_write_enable = ~push_fault;
                    mem_write_data   = DW'(flags_q);
                end
                default: mem_read_addr = sp_inc;
            endcase
        end
    end

    // Sequencer: SP, state and registered response fields
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            sp_q            <= SP_RESET;
            flags_q         <= '0;
            resp_valid_q    <= 1'b0;
            resp_pc_valid_q <= 1'b0;
            resp_data_q     <= '0;
            resp_pc_q       <= '0;
            resp_flags_q    <= '0;
        end else begin
            resp_valid_q    <= 1'b0;
            resp_pc_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        case (op)
                            OP_LOAD: begin
                                resp_data_q  <= mem_read_data;
                                resp_valid_q <= 1'b1;
                            end
                            OP_STORE: begin
                                resp_valid_q <= 1'b0;
                            end
                            OP_PUSH, OP_CALL: begin
                                if (!push_fault) sp_q <= sp_dec;
                            end
                            OP_POP: begin
                                resp_data_q  <= pop_fault ? '0 : mem_read_data;
                                resp_valid_q <= 1'b1;
                                if (!pop_fault) sp_q <= sp_inc;
                            end
                            OP_RET: begin
                                resp_pc_q       <= pop_fault ? '0 : mem_read_data;
                                resp_valid_q    <= 1'b1;
                                resp_pc_valid_q <= 1'b1;
                                if (!pop_fault) sp_q <= sp_inc;
                            end
                            OP_INT: begin
                                flags_q <= req_flags;
                                if (!push_fault) begin
                                    sp_q    <= sp_dec;
                                    state_q <= S_INT2;
                                end
                            end
                            OP_RTI: begin
                                resp_flags_q <= pop_fault ? '0 : mem_read_data[FLAG_W-1:0];
                                if (!pop_fault) sp_q <= sp_inc;
                                state_q <= S_RTI2;
                            end
                        endcase
                    end
                end
                S_INT2: begin
                    if (!push_fault) sp_q <= sp_dec;
                    state_q <= S_IDLE;
                end
                S_RTI2: begin
                    resp_pc_q       <= pop_fault ? '0 : mem_read_data;
                    resp_valid_q    <= 1'b1;
                    resp_pc_valid_q <= 1'b1;
                    if (!pop_fault) sp_q <= sp_inc;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign sp            = sp_q;
    assign resp_valid    = resp_valid_q;
    assign resp_pc_valid = resp_pc_valid_q;
    assign resp_data     = resp_data_q;
    assign resp_pc       = resp_pc_q;
    assign resp_flags    = resp_flags_q;

endmodule

// File: tb/tb_stack_mem_controller.sv
// Scoreboard bench for stack_mem_controller with a behavioural data memory.
module tb_stack_mem_controller;

    localparam logic [2:0] OP_LOAD = 3'd0, OP_STORE = 3'd1, OP_PUSH = 3'd2, OP_POP = 3'd3;
    localparam logic [2:0] OP_CALL = 3'd4, OP_RET = 3'd5, OP_INT = 3'd6, OP_RTI = 3'd7;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [2:0] req_op = '0;
    logic [7:0] req_addr = '0, req_data = '0, req_pc = '0;
    logic [3:0] req_flags = '0;
    logic       resp_valid, resp_pc_valid, stall;
    logic [7:0] resp_data, resp_pc, sp;
    logic [3:0] resp_flags;
    logic [7:0] mem_read_addr, mem_read_data, mem_write_addr, mem_write_data;
    logic       mem_write_enable;
`ifdef STACK_GUARD_EN
    logic       stack_fault;
`endif

    logic [7:0] mem [256];

    typedef struct {
        int         kind;   // 0 data, 1 ret, 2 rti
        logic [7:0] data;
        logic [7:0] pc;
        logic [3:0] flags;
    } exp_t;
    exp_t exp_q[$];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    stack_mem_controller dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_data(req_data), .req_pc(req_pc), .req_flags(req_flags),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_pc(resp_pc),
        .resp_flags(resp_flags), .resp_pc_valid(resp_pc_valid), .sp(sp),
`ifdef STACK_GUARD_EN
        .stack_fault(stack_fault),
`endif
        .stall(stall),
        .mem_read_addr(mem_read_addr), .mem_read_data(mem_read_data),
        .mem_write_enable(mem_write_enable), .mem_write_addr(mem_write_addr),
        .mem_write_data(mem_write_data)
    );

    assign mem_read_data = mem[mem_read_addr];
    always @(posedge clk) if (mem_write_enable) mem[mem_write_addr] <= mem_write_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] pc, input logic [3:0] f);
        req_valid = 1'b1; req_op = op; req_addr = a; req_data = d; req_pc = pc; req_flags = f;
    endtask

    task automatic tick();
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] pc, input logic [3:0] f);
        drive(op, a, d, pc, f);
        tick();
    endtask

    task automatic expect_resp(input int kind, input logic [7:0] d, input logic [7:0] pc,
                               input logic [3:0] f);
        exp_t e;
        e.kind = kind; e.data = d; e.pc = pc; e.flags = f;
        exp_q.push_back(e);
    endtask

    // Monitor: compare every response pulse against the scoreboard head
    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_resp_valid", 32'(resp_valid), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.kind == 0) begin
                    chk("resp_data", 32'(resp_data), 32'(e.data));
                    chk("resp_pc_valid_data", 32'(resp_pc_valid), 32'd0);
                end else begin
                    chk("resp_pc", 32'(resp_pc), 32'(e.pc));
                    chk("resp_pc_valid", 32'(resp_pc_valid), 32'd1);
                    if (e.kind == 2) chk("resp_flags", 32'(resp_flags), 32'(e.flags));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sp", 32'(sp), 32'hFF);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_we", 32'(mem_write_enable), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_data", 32'(resp_data), 32'd0);
        chk("rst_resp_pc", 32'(resp_pc), 32'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 32'(req_ready), 32'd1);

        // STORE then LOAD (write-then-read next cycle)
        issue(OP_STORE, 8'h10, 8'h5A, 8'h00, 4'h0);
        expect_resp(0, 8'h5A, 8'h00, 4'h0);
        issue(OP_LOAD, 8'h10, 8'h00, 8'h00, 4'h0);
        chk("store_mem10", 32'(mem[8'h10]), 32'h5A);

        // PUSH/PUSH/POP/POP
        issue(OP_PUSH, 8'h00, 8'hA1, 8'h00, 4'h0);
        chk("push1_sp", 32'(sp), 32'hFE);
        issue(OP_PUSH, 8'h00, 8'hB2, 8'h00, 4'h0);
        chk("push2_sp", 32'(sp), 32'hFD);
        chk("push_memFF", 32'(mem[8'hFF]), 32'hA1);
        chk("push_memFE", 32'(mem[8'hFE]), 32'hB2);
        expect_resp(0, 8'hB2, 8'h00, 4'h0);
        issue(OP_POP, 8'h00, 8'h00, 8'h00, 4'h0);
        chk("pop1_sp", 32'(sp), 32'hFE);
        expect_resp(0, 8'hA1, 8'h00, 4'h0);
        issue(OP_POP, 8'h00, 8'h00, 8'h00, 4'h0);
        chk("pop2_sp", 32'(sp), 32'hFF);

        // CALL/RET
        issue(OP_CALL, 8'h00, 8'h00, 8'h33, 4'h0);
        chk("call_memFF", 32'(mem[8'hFF]), 32'h33);
        chk("call_sp", 32'(sp), 32'hFE);
        expect_resp(1, 8'h00, 8'h33, 4'h0);
        issue(OP_RET, 8'h00, 8'h00, 8'h00, 4'h0);
        chk("ret_sp", 32'(sp), 32'hFF);

        // INT, two cycles
        drive(OP_INT, 8'h00, 8'h00, 8'h40, 4'b1010);
        #1 chk("int_accept_stall", 32'(stall), 32'd1);
        tick();
        chk("int2_stall", 32'(stall), 32'd1);
        chk("int2_ready", 32'(req_ready), 32'd0);
        chk("int2_we", 32'(mem_write_enable), 32'd1);
        tick();
        chk("int_done_stall", 32'(stall), 32'd0);
        chk("int_done_ready", 32'(req_ready), 32'd1);
        chk("int_memFF", 32'(mem[8'hFF]), 32'h40);
        chk("int_memFE", 32'(mem[8'hFE]), 32'h0A);
        chk("int_sp", 32'(sp), 32'hFD);

        // RTI, two cycles
        drive(OP_RTI, 8'h00, 8'h00, 8'h00, 4'h0);
        #1 chk("rti_accept_stall", 32'(stall), 32'd1);
        expect_resp(2, 8'h00, 8'h40, 4'b1010);
        tick();
        chk("rti2_ready", 32'(req_ready), 32'd0);
        chk("rti2_stall", 32'(stall), 32'd1);
        tick();
        chk("rti_sp", 32'(sp), 32'hFF);
        tick();
        chk("rti_resp_flags_hold", 32'(resp_flags), 32'hA);

        // Reset during INT2 aborts the flags write
        issue(OP_INT, 8'h00, 8'h00, 8'h55, 4'h3);
        chk("int_abort_memFF", 32'(mem[8'hFF]), 32'h55);
        rst = 1'b1;
        #1 chk("rst_in_int2_we", 32'(mem_write_enable), 32'd0);
        @(posedge clk); #1;
        chk("int_abort_memFE", 32'(mem[8'hFE]), 32'h0A);
        chk("int_abort_sp", 32'(sp), 32'hFF);
        rst = 1'b0;
        #1 chk("int_abort_idle", 32'(req_ready), 32'd1);

        // POP at the top of stack
        issue(OP_STORE, 8'h00, 8'h77, 8'h00, 4'h0);
`ifdef STACK_GUARD_EN
        expect_resp(0, 8'h00, 8'h00, 4'h0);
        issue(OP_POP, 8'h00, 8'h00, 8'h00, 4'h0);
        chk("guard_fault", 32'(stack_fault), 32'd1);
        chk("guard_sp", 32'(sp), 32'hFF);
`else
        expect_resp(0, 8'h77, 8'h00, 4'h0);
        issue(OP_POP, 8'h00, 8'h00, 8'h00, 4'h0);
        chk("wrap_pop_sp", 32'(sp), 32'h00);
        issue(OP_PUSH, 8'h00, 8'hC3, 8'h00, 4'h0);
        chk("wrap_push_sp", 32'(sp), 32'hFF);
        chk("wrap_push_mem00", 32'(mem[8'h00]), 32'hC3);
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
